// File: rtl/div_pkg.sv
// Shared definitions for the sequential 12/5 restoring divider.
// State encoding, default widths, iteration count and divide-by-zero results.
package div_pkg;

    localparam int WN_DEF = 12;
    localparam int WD_DEF = 5;
    localparam int N_ITER = WN_DEF;

    localparam logic [WN_DEF-1:0] Q_DBZ = 12'hFFF;
    localparam logic [WD_DEF-1:0] R_DBZ = 5'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports: p_i partial remainder, bit_i next dividend bit, d_i |divisor|;
//        p_o new partial remainder, q_o quotient bit.
module div_step #(
    parameter int WD = 5
) (
    input  logic [WD-1:0] p_i,
    input  logic          bit_i,
    input  logic [WD-1:0] d_i,
    output logic [WD-1:0] p_o,
    output logic          q_o
);

    // Shifted remainder is one bit wider than the divisor.
    logic [WD:0]   t;
    logic [WD-1:0] diff;
    logic          ge;

    assign t    = {p_i, bit_i};
    assign ge   = t >= {1'b0, d_i};
    // When ge holds the difference is below d_i, so the low bits suffice.
    assign diff = t[WD-1:0] - d_i;

    assign p_o = ge ? diff : t[WD-1:0];
    assign q_o = ge;

endmodule

// File: rtl/seq_div_12x5.sv
// Sequential restoring divider, 12-bit dividend by 5-bit divisor, signed or unsigned.
// Ports: clk, rst_n, N/D/T/start in; busy, done, Q, R, dbz, ovf out.
module seq_div_12x5
    import div_pkg::*;
#(
    parameter int WN = WN_DEF,
    parameter int WD = WD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [WN-1:0] N,
    input  logic [WD-1:0] D,
    input  logic          T,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [WN-1:0] Q,
    output logic [WD-1:0] R,
    output logic          dbz,
    output logic          ovf
);

    localparam int CW = $clog2(WN);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [WN-1:0] dvd_q;
    logic [WD-1:0] dabs_q;
    logic [WD-1:0] p_q;
    logic          sn_q;
    logic          sd_q;
    logic          dbz_pend_q;
    logic          ovf_pend_q;
    logic          busy_q;
    logic          done_q;
    logic [WN-1:0] q_q;
    logic [WD-1:0] r_q;
    logic          dbz_q;
    logic          ovf_q;

    logic          n_neg_d;
    logic          d_neg_d;
    logic [WN-1:0] n_abs_d;
    logic [WD-1:0] d_abs_d;
    logic          ovf_d;
    logic [WD-1:0] p_d;
    logic          qbit_d;
    logic [WN-1:0] q_res_d;
    logic [WD-1:0] r_res_d;

    // Magnitudes; -(-2048) wraps to 12'h800, which is the right unsigned value.
    assign n_neg_d = T & N[WN-1];
    assign d_neg_d = T & D[WD-1];
    assign n_abs_d = n_neg_d ? -N : N;
    assign d_abs_d = d_neg_d ? -D : D;
    assign ovf_d   = T && (N == {1'b1, {(WN-1){1'b0}}}) && (D == '1);

    div_step #(
        .WD(WD)
    ) u_step (
        .p_i  (p_q),
        .bit_i(dvd_q[WN-1]),
        .d_i  (dabs_q),
        .p_o  (p_d),
        .q_o  (qbit_d)
    );

    // Truncation toward zero: remainder follows the dividend's sign.
    assign q_res_d = (sn_q ^ sd_q) ? -dvd_q : dvd_q;
    assign r_res_d = sn_q ? -p_q : p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dabs_q     <= '0;
            p_q        <= '0;
            sn_q       <= 1'b0;
            sd_q       <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q     <= 1'b1;
                        dbz_q      <= 1'b0;
                        ovf_q      <= 1'b0;
                        sn_q       <= n_neg_d;
                        sd_q       <= d_neg_d;
                        dvd_q      <= n_abs_d;
                        dabs_q     <= d_abs_d;
                        p_q        <= '0;
                        cnt_q      <= '0;
                        dbz_pend_q <= (D == '0);
                        ovf_pend_q <= ovf_d;
                        state_q    <= (D == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    // Dividend shifts out at the top, quotient bits fill in below.
                    p_q   <= p_d;
                    dvd_q <= {dvd_q[WN-2:0], qbit_d};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WN - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (dbz_pend_q) begin
                        q_q   <= WN'(Q_DBZ);
                        r_q   <= WD'(R_DBZ);
                        dbz_q <= 1'b1;
                    end else begin
                        q_q   <= q_res_d;
                        r_q   <= r_res_d;
                        ovf_q <= ovf_pend_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign dbz  = dbz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_div_12x5.sv
// Self-checking bench for seq_div_12x5: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_seq_div_12x5;

    logic        clk;
    logic        rst_n;
    logic [11:0] n_s;
    logic [4:0]  d_s;
    logic        t_s;
    logic        start;
    logic        busy;
    logic        done;
    logic [11:0] q_o;
    logic [4:0]  r_o;
    logic        dbz;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div_12x5 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .N    (n_s),
        .D    (d_s),
        .T    (t_s),
        .start(start),
        .busy (busy),
        .done (done),
        .Q    (q_o),
        .R    (r_o),
        .dbz  (dbz),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(
        input  logic [11:0] n,
        input  logic [4:0]  d,
        input  logic        t,
        output logic [11:0] q,
        output logic [4:0]  r,
        output logic        z,
        output logic        o
    );
        int sn, sd, qi, ri;
        sn = t ? int'($signed(n)) : int'(n);
        sd = t ? int'($signed(d)) : int'(d);
        z = 1'b0;
        o = 1'b0;
        if (sd == 0) begin
            q = 12'hFFF;
            r = 5'h0;
            z = 1'b1;
        end else if (t && sn == -2048 && sd == -1) begin
            q = 12'h800;
            r = 5'h0;
            o = 1'b1;
        end else begin
            qi = sn / sd;
            ri = sn % sd;
            q = qi[11:0];
            r = ri[4:0];
        end
    endfunction

    // Starts one op from just after an edge; returns clocks from accept to done.
    task automatic run_op(
        input  logic [11:0] n,
        input  logic [4:0]  d,
        input  logic        t,
        output int          cyc,
        output logic        busy_ok
    );
        n_s   = n;
        d_s   = d;
        t_s   = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        cyc     = 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        n_s   = '0;
        d_s   = '0;
        t_s   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (q_o !== 12'h0) begin n_fail++; $display("FAIL reset_q got %h want 000", q_o); end
        n_checks++; if (r_o !== 5'h0) begin n_fail++; $display("FAIL reset_r got %h want 00", r_o); end
        n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %0b want 0", dbz); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        int   cyc;
        logic bok;
        run_op(12'd3937, 5'd31, 1'b0, cyc, bok);
        n_checks++; if (cyc != 13) begin n_fail++; $display("FAIL uns_latency got %0d want 13", cyc); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL uns_busy got low want high"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL uns_busy_done got %0b want 0", busy); end
        n_checks++; if (q_o !== 12'd127) begin n_fail++; $display("FAIL uns_q got %0d want 127", q_o); end
        n_checks++; if (r_o !== 5'd0) begin n_fail++; $display("FAIL uns_r got %0d want 0", r_o); end
        n_checks++; if (dbz !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL uns_flags got %0b%0b want 00", dbz, ovf); end
        n_s = 12'h123;
        d_s = 5'h3;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL uns_done_pulse got %0b want 0", done); end
        n_checks++; if (q_o !== 12'd127) begin n_fail++; $display("FAIL uns_q_hold got %0d want 127", q_o); end
    endtask

    task automatic test_signed();
        logic [11:0] nv [3] = '{12'hC4F, 12'd100, 12'hF9C};
        logic [4:0]  dv [3] = '{5'd15, 5'h19, 5'd7};
        logic [11:0] qv [3] = '{12'hFC1, 12'hFF2, 12'hFF2};
        logic [4:0]  rv [3] = '{5'd0, 5'd2, 5'h1E};
        int   cyc;
        logic bok;
        for (int i = 0; i < 3; i++) begin
            run_op(nv[i], dv[i], 1'b1, cyc, bok);
            n_checks++; if (cyc != 13) begin n_fail++; $display("FAIL sgn%0d_latency got %0d want 13", i, cyc); end
            n_checks++; if (q_o !== qv[i]) begin n_fail++; $display("FAIL sgn%0d_q got %h want %h", i, q_o, qv[i]); end
            n_checks++; if (r_o !== rv[i]) begin n_fail++; $display("FAIL sgn%0d_r got %h want %h", i, r_o, rv[i]); end
        end
    endtask

    task automatic test_boundaries();
        int   cyc;
        logic bok;
        for (int m = 0; m < 2; m++) begin
            run_op(12'h5A5, 5'd0, m[0], cyc, bok);
            n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL dbz%0d_latency got %0d want 1", m, cyc); end
            n_checks++; if (q_o !== 12'hFFF) begin n_fail++; $display("FAIL dbz%0d_q got %h want fff", m, q_o); end
            n_checks++; if (r_o !== 5'd0) begin n_fail++; $display("FAIL dbz%0d_r got %h want 00", m, r_o); end
            n_checks++; if (dbz !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL dbz%0d_flags got %0b%0b want 10", m, dbz, ovf); end
        end
        run_op(12'h800, 5'h1F, 1'b1, cyc, bok);
        n_checks++; if (q_o !== 12'h800 || r_o !== 5'd0) begin n_fail++; $display("FAIL ovf_qr got %h/%h want 800/00", q_o, r_o); end
        n_checks++; if (ovf !== 1'b1 || dbz !== 1'b0) begin n_fail++; $display("FAIL ovf_flags got %0b%0b want 01", dbz, ovf); end
        run_op(12'hFFF, 5'h1F, 1'b0, cyc, bok);
        n_checks++; if (q_o !== 12'd132 || r_o !== 5'd3) begin n_fail++; $display("FAIL maxu_qr got %0d/%0d want 132/3", q_o, r_o); end
        n_checks++; if (ovf !== 1'b0 || dbz !== 1'b0) begin n_fail++; $display("FAIL maxu_flags got %0b%0b want 00", dbz, ovf); end
    endtask

    task automatic test_ignore_start();
        int cyc;
        n_s   = 12'd1000;
        d_s   = 5'd7;
        t_s   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (cyc < 40) begin
            start = (cyc == 3 || cyc == 10);
            n_s   = 12'($urandom);
            d_s   = 5'($urandom_range(1, 31));
            t_s   = 1'($urandom);
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (done === 1'b1) break;
        end
        n_checks++; if (cyc != 13) begin n_fail++; $display("FAIL ign_latency got %0d want 13", cyc); end
        n_checks++; if (q_o !== 12'd142 || r_o !== 5'd6) begin n_fail++; $display("FAIL ign_qr got %0d/%0d want 142/6", q_o, r_o); end
        repeat (15) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue got busy %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic bok;
        run_op(12'd3000, 5'd9, 1'b0, cyc, bok);
        run_op(12'd40, 5'd8, 1'b0, cyc, bok);
        n_checks++; if (!bok) begin n_fail++; $display("FAIL b2b_accept got busy %0b done %0b want 1 0", busy, done); end
        n_checks++; if (cyc != 13) begin n_fail++; $display("FAIL b2b_latency got %0d want 13", cyc); end
        n_checks++; if (q_o !== 12'd5 || r_o !== 5'd0) begin n_fail++; $display("FAIL b2b_qr got %0d/%0d want 5/0", q_o, r_o); end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        int   seen;
        logic bok;
        n_s   = 12'd2500;
        d_s   = 5'd13;
        t_s   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_bd got %0b%0b want 00", busy, done); end
        n_checks++; if (q_o !== 12'h0 || r_o !== 5'h0) begin n_fail++; $display("FAIL rmid_qr got %h/%h want 000/00", q_o, r_o); end
        n_checks++; if (dbz !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got %0b%0b want 00", dbz, ovf); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_done got %0d active cycles want 0", seen); end
        run_op(12'd2048, 5'd16, 1'b0, cyc, bok);
        n_checks++; if (cyc != 13) begin n_fail++; $display("FAIL rmid_after_latency got %0d want 13", cyc); end
        n_checks++; if (q_o !== 12'd128 || r_o !== 5'd0) begin n_fail++; $display("FAIL rmid_after_qr got %0d/%0d want 128/0", q_o, r_o); end
    endtask

    task automatic test_random();
        int          cyc;
        logic        bok;
        logic [11:0] n, eq;
        logic [4:0]  d, er;
        logic        t, ez, eo;
        for (int i = 0; i < 300; i++) begin
            n = 12'($urandom);
            d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            t = 1'($urandom);
            if (i % 50 == 0) begin
                n = 12'h800;
                d = 5'h1F;
            end
            model(n, d, t, eq, er, ez, eo);
            run_op(n, d, t, cyc, bok);
            n_checks++;
            if (q_o !== eq || r_o !== er || dbz !== ez || ovf !== eo ||
                cyc != (ez ? 1 : 13) || !bok) begin
                n_fail++;
                $display("FAIL rand%0d n=%h d=%h t=%0b got q=%h r=%h z=%0b o=%0b cyc=%0d want q=%h r=%h z=%0b o=%0b",
                         i, n, d, t, q_o, r_o, dbz, ovf, cyc, eq, er, ez, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_boundaries();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
